// File: rtl/spell_mem_pkg.sv
// Shared types and defaults for the spell memory arbiter.
package spell_mem_pkg;

   // Backend channel chosen for a request
   typedef enum logic [1:0] {
      TGT_IO,
      TGT_INT,
      TGT_SPI
   } target_e;

   // Request/response FSM states
   typedef enum logic [1:0] {
      StIdle,
      StAccess,
      StRelease
   } state_e;

   // Default data-space IO window: [DEF_IO_BASE, DEF_IO_LIMIT)
   localparam int unsigned DEF_IO_BASE  = 'h20;
   localparam int unsigned DEF_IO_LIMIT = 'h60;

endpackage

// File: rtl/spell_mem_decode.sv
// Address decoder: maps a request onto the IO, internal-RAM or SPI-memory channel.
module spell_mem_decode
   import spell_mem_pkg::*;
#(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned IO_BASE  = DEF_IO_BASE,
   parameter int unsigned IO_LIMIT = DEF_IO_LIMIT
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic              type_data,
   input  logic              spimem_enabled,
   output target_e           target
);

   logic [31:0] addr_ext;
   logic        in_window;

   assign addr_ext  = 32'(addr);
   assign in_window = (addr_ext >= IO_BASE) && (addr_ext < IO_LIMIT);

   // Only data space can hit the IO window; everything else is memory
   always_comb begin
      target = spimem_enabled ? TGT_SPI : TGT_INT;
      if (type_data && in_window) begin
         target = TGT_IO;
      end
   end

endmodule

// File: rtl/spell_mem_arbiter.sv
// Spell memory front-end: registered request/response arbiter with timeout and bus error.
module spell_mem_arbiter
   import spell_mem_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 8,
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       IO_BASE  = DEF_IO_BASE,
   parameter int unsigned       IO_LIMIT = DEF_IO_LIMIT,
   parameter int unsigned       TIMEOUT  = 255,
   parameter int unsigned       TO_W     = 8,
   parameter logic [DATA_W-1:0] ERR_DATA = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              select,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   input  logic              memory_type_data,
   input  logic              write,
   output logic [DATA_W-1:0] data_out,
   output logic              data_ready,
   output logic              bus_error,
   input  logic              boot_strap,
   output logic              spimem_enabled,
   output logic [ADDR_W-1:0] b_addr,
   output logic [DATA_W-1:0] b_wdata,
   output logic              b_write,
   output logic              b_type_data,
   output logic              io_sel,
   output logic              int_sel,
   output logic              spi_sel,
   input  logic              io_ready,
   input  logic              int_ready,
   input  logic              spi_ready,
   input  logic [DATA_W-1:0] io_rdata,
   input  logic [DATA_W-1:0] int_rdata,
   input  logic [DATA_W-1:0] spi_rdata
);

   // Counter value after which one more idle ACCESS cycle means timeout
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   target_e           tgt_q, tgt_d, tgt_dec;
   logic [TO_W-1:0]   cnt_q, cnt_d;
   logic              sel_q, sel_d;
   logic              ready_q, ready_d;
   logic              err_q, err_d;
   logic              spimem_q;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [ADDR_W-1:0] baddr_q, baddr_d;
   logic [DATA_W-1:0] bwdata_q, bwdata_d;
   logic              bwrite_q, bwrite_d;
   logic              btype_q, btype_d;
   logic              tgt_ready;
   logic [DATA_W-1:0] tgt_rdata;

   spell_mem_decode #(
      .ADDR_W   (ADDR_W),
      .IO_BASE  (IO_BASE),
      .IO_LIMIT (IO_LIMIT)
   ) u_decode (
      .addr           (addr),
      .type_data      (memory_type_data),
      .spimem_enabled (spimem_q),
      .target         (tgt_dec)
   );

   // Observe only the latched target's ready/rdata; other channels are ignored
   always_comb begin
      tgt_ready = 1'b0;
      tgt_rdata = '0;
      unique case (tgt_q)
         TGT_IO:  begin tgt_ready = io_ready;  tgt_rdata = io_rdata;  end
         TGT_INT: begin tgt_ready = int_ready; tgt_rdata = int_rdata; end
         TGT_SPI: begin tgt_ready = spi_ready; tgt_rdata = spi_rdata; end
         default: ;
      endcase
   end

   // Next-state logic for the request FSM, timeout counter and latches
   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      ready_d  = 1'b0;
      err_d    = 1'b0;
      dout_d   = dout_q;
      baddr_d  = baddr_q;
      bwdata_d = bwdata_q;
      bwrite_d = bwrite_q;
      btype_d  = btype_q;
      unique case (state_q)
         StIdle: begin
            if (select) begin
               baddr_d  = addr;
               bwdata_d = data_in;
               bwrite_d = write;
               btype_d  = memory_type_data;
               tgt_d    = tgt_dec;
               cnt_d    = '0;
               sel_d    = 1'b1;
               state_d  = StAccess;
            end
         end
         StAccess: begin
            if (!select) begin
               // Requester gave up: drop the channel quietly
               sel_d   = 1'b0;
               state_d = StIdle;
            end else if (tgt_ready) begin
               sel_d   = 1'b0;
               ready_d = 1'b1;
               if (!bwrite_q) dout_d = tgt_rdata;
               state_d = StRelease;
            end else if (cnt_q == TO_LAST) begin
               sel_d   = 1'b0;
               ready_d = 1'b1;
               err_d   = 1'b1;
               if (!bwrite_q) dout_d = ERR_DATA;
               state_d = StRelease;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRelease: begin
            // Force a select-low cycle between requests
            if (!select) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State register; strap is resampled on every reset cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         tgt_q    <= TGT_IO;
         cnt_q    <= '0;
         sel_q    <= 1'b0;
         ready_q  <= 1'b0;
         err_q    <= 1'b0;
         dout_q   <= '0;
         baddr_q  <= '0;
         bwdata_q <= '0;
         bwrite_q <= 1'b0;
         btype_q  <= 1'b0;
         spimem_q <= boot_strap;
      end else begin
         state_q  <= state_d;
         tgt_q    <= tgt_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
         dout_q   <= dout_d;
         baddr_q  <= baddr_d;
         bwdata_q <= bwdata_d;
         bwrite_q <= bwrite_d;
         btype_q  <= btype_d;
      end
   end

   assign io_sel         = sel_q && (tgt_q == TGT_IO);
   assign int_sel        = sel_q && (tgt_q == TGT_INT);
   assign spi_sel        = sel_q && (tgt_q == TGT_SPI);
   assign data_out       = dout_q;
   assign data_ready     = ready_q;
   assign bus_error      = err_q;
   assign spimem_enabled = spimem_q;
   assign b_addr         = baddr_q;
   assign b_wdata        = bwdata_q;
   assign b_write        = bwrite_q;
   assign b_type_data    = btype_q;

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Directed self-checking bench for spell_mem_arbiter.
module tb_spell_mem_arbiter;
   import spell_mem_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       select;
   logic [7:0] addr;
   logic [7:0] data_in;
   logic       memory_type_data;
   logic       write;
   logic [7:0] data_out;
   logic       data_ready;
   logic       bus_error;
   logic       boot_strap;
   logic       spimem_enabled;
   logic [7:0] b_addr;
   logic [7:0] b_wdata;
   logic       b_write;
   logic       b_type_data;
   logic       io_sel, int_sel, spi_sel;
   logic       io_ready, int_ready, spi_ready;
   logic [7:0] io_rdata, int_rdata, spi_rdata;

   logic [7:0] ref_addr;
   logic       ref_type;
   logic       ref_spi;
   target_e    ref_tgt;

   int checks = 0;
   int errors = 0;
   int onehot_viol = 0;

   spell_mem_arbiter #(
      .ADDR_W   (8),
      .DATA_W   (8),
      .IO_BASE  ('h20),
      .IO_LIMIT ('h60),
      .TIMEOUT  (255),
      .TO_W     (8),
      .ERR_DATA (8'hFF)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .select           (select),
      .addr             (addr),
      .data_in          (data_in),
      .memory_type_data (memory_type_data),
      .write            (write),
      .data_out         (data_out),
      .data_ready       (data_ready),
      .bus_error        (bus_error),
      .boot_strap       (boot_strap),
      .spimem_enabled   (spimem_enabled),
      .b_addr           (b_addr),
      .b_wdata          (b_wdata),
      .b_write          (b_write),
      .b_type_data      (b_type_data),
      .io_sel           (io_sel),
      .int_sel          (int_sel),
      .spi_sel          (spi_sel),
      .io_ready         (io_ready),
      .int_ready        (int_ready),
      .spi_ready        (spi_ready),
      .io_rdata         (io_rdata),
      .int_rdata        (int_rdata),
      .spi_rdata        (spi_rdata)
   );

   spell_mem_decode #(
      .ADDR_W   (8),
      .IO_BASE  ('h20),
      .IO_LIMIT ('h60)
   ) u_ref (
      .addr           (ref_addr),
      .type_data      (ref_type),
      .spimem_enabled (ref_spi),
      .target         (ref_tgt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // At most one channel select may be high at any time
   always @(negedge clk) begin
      if ((io_sel & int_sel) | (io_sel & spi_sel) | (int_sel & spi_sel)) onehot_viol++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] selv();
      return {29'b0, io_sel, int_sel, spi_sel};
   endfunction

   // One request: sel at cycle 1, ready after 'delay' more cycles, data_ready the cycle after
   task automatic run_req(input string tag, input logic [7:0] a, input logic td,
                          input logic wr, input logic [7:0] wd, input logic [2:0] ch,
                          input int delay, input logic [7:0] rd);
      select = 1'b1; addr = a; memory_type_data = td; write = wr; data_in = wd;
      tick();
      check({tag, " sel"}, selv(), {29'b0, ch});
      check({tag, " b_addr"}, b_addr, a);
      check({tag, " b_wdata"}, b_wdata, wd);
      check({tag, " b_write"}, b_write, wr);
      check({tag, " b_type"}, b_type_data, td);
      for (int i = 0; i < delay; i++) tick();
      check({tag, " early ready"}, data_ready, 0);
      io_ready  = ch[2]; int_ready = ch[1]; spi_ready = ch[0];
      io_rdata  = ch[2] ? rd : ~rd;
      int_rdata = ch[1] ? rd : ~rd;
      spi_rdata = ch[0] ? rd : ~rd;
      tick();
      check({tag, " data_ready"}, data_ready, 1);
      check({tag, " bus_error"}, bus_error, 0);
      check({tag, " sel drop"}, selv(), 0);
      io_ready = 1'b0; int_ready = 1'b0; spi_ready = 1'b0;
      select = 1'b0;
      tick();
      check({tag, " ready pulse"}, data_ready, 0);
   endtask

   initial begin
      logic seen, dropped;
      rst_n = 1'b0; boot_strap = 1'b1; select = 1'b0; addr = '0; data_in = '0;
      memory_type_data = 1'b0; write = 1'b0;
      io_ready = 1'b0; int_ready = 1'b0; spi_ready = 1'b0;
      io_rdata = '0; int_rdata = '0; spi_rdata = '0;
      ref_addr = '0; ref_type = 1'b0; ref_spi = 1'b0;

      // Reference decoder spot checks
      ref_type = 1'b1; ref_addr = 8'h1F; #1 check("dec 1F", ref_tgt, TGT_INT);
      ref_addr = 8'h20; #1 check("dec 20", ref_tgt, TGT_IO);
      ref_addr = 8'h5F; #1 check("dec 5F", ref_tgt, TGT_IO);
      ref_addr = 8'h60; #1 check("dec 60", ref_tgt, TGT_INT);
      ref_type = 1'b0; ref_addr = 8'h30; ref_spi = 1'b1; #1 check("dec code", ref_tgt, TGT_SPI);

      // Reset with strap high
      tick(); tick(); tick();
      check("rst sel", selv(), 0);
      check("rst data_ready", data_ready, 0);
      check("rst bus_error", bus_error, 0);
      check("rst data_out", data_out, 0);
      check("rst b_addr", b_addr, 0);
      check("rst strap", spimem_enabled, 1);
      rst_n = 1'b1; boot_strap = 1'b0;
      tick();
      check("strap held", spimem_enabled, 1);

      // Strap test: SPI read, ready at cycle 4
      run_req("spi rd", 8'h10, 1'b1, 1'b0, 8'h00, 3'b001, 3, 8'hA5);
      check("spi rd data", data_out, 8'hA5);

      // Re-reset with strap low
      rst_n = 1'b0; boot_strap = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      tick();
      check("strap low", spimem_enabled, 0);

      // IO window
      run_req("int rd 61", 8'h61, 1'b1, 1'b0, 8'h00, 3'b010, 1, 8'h5A);
      check("int rd data", data_out, 8'h5A);
      run_req("io wr 20", 8'h20, 1'b1, 1'b1, 8'h3C, 3'b100, 0, 8'hC3);
      check("io wr 20 dout", data_out, 8'h5A);
      run_req("io wr 5F", 8'h5F, 1'b1, 1'b1, 8'h3C, 3'b100, 2, 8'hC3);
      run_req("int wr 60", 8'h60, 1'b1, 1'b1, 8'h3C, 3'b010, 0, 8'hC3);
      run_req("int wr code", 8'h30, 1'b0, 1'b1, 8'h3C, 3'b010, 0, 8'hC3);
      check("writes dout", data_out, 8'h5A);

      // Stray ready on IO during an internal access
      select = 1'b1; addr = 8'h70; memory_type_data = 1'b1; write = 1'b0;
      tick();
      check("stray int_sel", selv(), 3'b010);
      io_ready = 1'b1; io_rdata = 8'hEE;
      tick();
      check("stray ignored", data_ready, 0);
      check("stray sel held", selv(), 3'b010);
      io_ready = 1'b0;
      tick(); tick();
      int_ready = 1'b1; int_rdata = 8'h77;
      tick();
      check("stray done", data_ready, 1);
      check("stray data", data_out, 8'h77);
      int_ready = 1'b0; select = 1'b0;
      tick();

      // Timeout on internal RAM
      select = 1'b1; addr = 8'h80; memory_type_data = 1'b1; write = 1'b0;
      seen = 1'b0; dropped = 1'b0;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (data_ready) seen = 1'b1;
         if (!int_sel) dropped = 1'b1;
      end
      check("to early ready", seen, 0);
      check("to sel held", dropped, 0);
      tick();
      check("to data_ready", data_ready, 1);
      check("to bus_error", bus_error, 1);
      check("to data", data_out, 8'hFF);
      check("to sel", selv(), 0);

      // Hold select after completion: no second pulse
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (data_ready || bus_error || int_sel) seen = 1'b1;
      end
      check("hold quiet", seen, 0);
      select = 1'b0;
      tick();
      select = 1'b1; addr = 8'h81;
      tick();
      check("reissue sel", selv(), 3'b010);
      int_ready = 1'b1; int_rdata = 8'h42;
      tick();
      check("reissue ready", data_ready, 1);
      check("reissue data", data_out, 8'h42);
      check("reissue err", bus_error, 0);
      int_ready = 1'b0; select = 1'b0;
      tick();

      // Abort in ACCESS
      select = 1'b1; addr = 8'h10; memory_type_data = 1'b1; write = 1'b0;
      tick();
      check("abort sel", selv(), 3'b010);
      select = 1'b0;
      tick();
      check("abort drop", selv(), 0);
      check("abort no ready", data_ready, 0);
      tick();
      check("abort no ready2", data_ready, 0);
      check("abort dout", data_out, 8'h42);

      // Reset mid-access
      rst_n = 1'b0; boot_strap = 1'b1;
      tick(); tick();
      rst_n = 1'b1; boot_strap = 1'b0;
      tick();
      select = 1'b1; addr = 8'h10; memory_type_data = 1'b1; write = 1'b0;
      tick();
      check("mid spi_sel", selv(), 3'b001);
      tick();
      rst_n = 1'b0;
      tick();
      check("mid rst sel", selv(), 0);
      check("mid rst dout", data_out, 0);
      check("mid rst ready", data_ready, 0);
      check("mid rst strap", spimem_enabled, 0);
      rst_n = 1'b1; select = 1'b0;
      tick();
      check("mid after ready", data_ready, 0);
      run_req("post rst", 8'h10, 1'b1, 1'b0, 8'h00, 3'b010, 0, 8'h3E);
      check("post rst data", data_out, 8'h3E);

      check("onehot", onehot_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/spell_mem_arbiter.md
Name: spell_mem_arbiter

Overview:
- Parametrised successor to the spell memory front-end.
- Decodes one CPU-side request (code/data space, address) to one of three backend channels: IO, internal RAM, SPI memory.
- Replaces the combinational select/ready OR-ing with a registered request/response FSM, per-request timeout, bus-error reporting and a configurable IO window.
- Sits between the spell core and the IO, internal-RAM and SPI-memory blocks.

Parameters:
ADDR_W, 8, address width of requests and backend address bus
DATA_W, 8, data width
IO_BASE, 'h20, first data-space address routed to IO (inclusive)
IO_LIMIT, 'h60, end of IO window (exclusive); IO_BASE < IO_LIMIT <= 2**ADDR_W
TIMEOUT, 255, max cycles a backend may take before bus error; 1..2**TO_W-1
TO_W, 8, timeout counter width
ERR_DATA, all-ones, data_out value returned on timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
select  in  1  request valid; held by requester until data_ready
addr  in  ADDR_W  request address
data_in  in  DATA_W  write data
memory_type_data  in  1  1=data space, 0=code space
write  in  1  1=write, 0=read
data_out  out  DATA_W  registered read data
data_ready  out  1  one-cycle completion pulse
bus_error  out  1  one-cycle pulse with data_ready when request timed out
boot_strap  in  1  backend strap, sampled during reset (tied to SPI MISO)
spimem_enabled  out  1  latched strap: 1 = non-IO memory goes to SPI
b_addr  out  ADDR_W  latched address to all backends
b_wdata  out  DATA_W  latched write data
b_write  out  1  latched write flag
b_type_data  out  1  latched memory_type_data
io_sel, int_sel, spi_sel  out  1 each  channel selects, at most one high
io_ready, int_ready, spi_ready  in  1 each  channel completion
io_rdata, int_rdata, spi_rdata  in  DATA_W each  channel read data, valid with ready

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; all *_sel, data_ready, bus_error = 0; data_out = 0; b_* = 0; timeout counter 0; spimem_enabled <= boot_strap every reset cycle, held after release.
- Decode on addr/memory_type_data captured in IDLE:
  - data space with IO_BASE <= addr < IO_LIMIT -> IO;
  - otherwise (code space, or data space outside the window) -> SPI if spimem_enabled, else internal.
  - Code space never reaches IO.
- States IDLE, ACCESS, RELEASE.
- IDLE: on select=1, latch addr/data_in/write/memory_type_data into b_*, latch target, clear counter, go ACCESS. Target *_sel goes high the next cycle (cycle 1).
- ACCESS:
  - Selected *_sel held high.
  - Only the selected channel's ready is observed; ready on other channels is ignored.
  - Selected ready=1: data_out <= that channel's rdata (reads only; writes leave data_out unchanged); data_ready=1 next cycle; *_sel drops that same cycle; go RELEASE.
  - Counter increments each ACCESS cycle without ready. When it reaches TIMEOUT: drop *_sel, data_out <= ERR_DATA (reads only), data_ready=1 and bus_error=1 for one cycle, go RELEASE.
  - Ready in the same cycle the counter would hit TIMEOUT counts as success.
  - select=0 in ACCESS (abort): drop *_sel next cycle, no data_ready, go IDLE.
- RELEASE: wait for select=0, then IDLE. A new request needs at least one select-low cycle. data_ready is never re-asserted while select stays high.
- Minimum latency: select at cycle 0, backend ready at cycle 1 -> data_ready at cycle 2.
- data_out holds its value between requests.
- Reset mid-ACCESS: *_sel drops on that edge; no data_ready; the strap is resampled.
- Invariant: io_sel+int_sel+spi_sel <= 1 every cycle.

Decomposition:
- Package spell_mem_pkg:
  - target enum (TGT_IO, TGT_INT, TGT_SPI);
  - FSM state enum;
  - default IO window constants.
- Sub-module spell_mem_decode: combinational addr/type/spimem_enabled -> target, parametrised by ADDR_W, IO_BASE, IO_LIMIT. Reused by the bench as a reference model.
- FSM, timeout counter and latches stay in the top.

Test Plan:
- Strap: boot_strap=1 during reset, then 0 -> spimem_enabled=1. Data read at 'h10 -> spi_sel at cycle 1; spi_ready+rdata 'hA5 at cycle 4 -> data_out='hA5, data_ready pulse at cycle 5.
- IO window: data write 'h20 and 'h5F -> io_sel; data 'h60 and code 'h30 -> int_sel (strap 0). b_wdata='h3C, b_write=1 during writes; data_out unchanged after writes.
- Timeout: int_ready never asserted, TIMEOUT=255 -> data_ready+bus_error at cycle 256, data_out='hFF, int_sel low from then on.
- Stray ready: io_ready pulsed during an internal access is ignored. int_ready 3 cycles later completes with int_rdata.
- Abort/hold: select dropped in ACCESS -> sel low next cycle, no data_ready. select held after completion -> no second data_ready; select low 1 cycle then high -> new access.
- Reset mid-access: rst_n low while spi_sel=1 -> all sel 0, data_out 0, state IDLE, no data_ready.
